// File: rtl/l2_arb_pkg.sv
// Shared types and default widths for the L1-to-L2 request arbiter.
package l2_arb_pkg;

  localparam int unsigned DefAddrW = 32;
  localparam int unsigned DefLineW = 256;
  localparam int unsigned DefCntW  = 32;

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

  typedef enum logic {OWN_I, OWN_D} owner_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at its maximum value instead of wrapping.
module sat_counter #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;

  // Count register; holds once all ones.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else if (inc && (count_q != {W{1'b1}})) begin
      count_q <= count_q + 1'b1;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/l2_arbiter.sv
// Round-robin arbiter sharing the L2 request port between the L1 I-cache and D-cache.
// The winner is latched into a capture register that alone drives the L2 port until
// the L2 responds; the response pulse is routed back to the owner combinationally.
module l2_arbiter
  import l2_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned LINE_W = DefLineW,
  parameter int unsigned CNT_W  = DefCntW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              l2_read,
  output logic              l2_write,
  output logic [ADDR_W-1:0] l2_addr,
  output logic [LINE_W-1:0] l2_wdata,
  input  logic [LINE_W-1:0] l2_rdata,
  input  logic              l2_resp,
  output logic [CNT_W-1:0]  cnt_i_grant,
  output logic [CNT_W-1:0]  cnt_d_grant,
  output logic [CNT_W-1:0]  cnt_conflict
);

  state_t              state_q, state_d;
  owner_t              last_q, last_d;
  logic                cap_read_q, cap_read_d;
  logic                cap_write_q, cap_write_d;
  logic [ADDR_W-1:0]   cap_addr_q, cap_addr_d;
  logic [LINE_W-1:0]   cap_wdata_q, cap_wdata_d;

  logic req_i, req_d, grant_i, grant_d, conflict;

  // Arbitration: on a tie the requester that did not win last time gets the port.
  always_comb begin
    req_i    = i_read;
    req_d    = d_read | d_write;
    conflict = (state_q == IDLE) & req_i & req_d;
    grant_i  = (state_q == IDLE) & req_i & (~req_d | (last_q == OWN_D));
    grant_d  = (state_q == IDLE) & req_d & ~grant_i;
  end

  // Next state, capture and response routing.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    cap_read_d  = cap_read_q;
    cap_write_d = cap_write_q;
    cap_addr_d  = cap_addr_q;
    cap_wdata_d = cap_wdata_q;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    unique case (state_q)
      IDLE: begin
        // l2_resp here is a protocol error and is dropped.
        if (grant_i) begin
          state_d     = BUSY_I;
          last_d      = OWN_I;
          cap_read_d  = 1'b1;
          cap_write_d = 1'b0;
          cap_addr_d  = i_addr;
          cap_wdata_d = '0;
        end else if (grant_d) begin
          // Write-back wins over a simultaneous read from the D-cache.
          state_d     = BUSY_D;
          last_d      = OWN_D;
          cap_read_d  = ~d_write;
          cap_write_d = d_write;
          cap_addr_d  = d_addr;
          cap_wdata_d = d_wdata;
        end
      end
      BUSY_I: begin
        if (l2_resp) begin
          i_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      BUSY_D: begin
        if (l2_resp) begin
          d_resp  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, round-robin pointer and capture register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= OWN_D;
      cap_read_q  <= 1'b0;
      cap_write_q <= 1'b0;
      cap_addr_q  <= '0;
      cap_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      cap_read_q  <= cap_read_d;
      cap_write_q <= cap_write_d;
      cap_addr_q  <= cap_addr_d;
      cap_wdata_q <= cap_wdata_d;
    end
  end

  // L2 port is fed only from the capture register; read data is broadcast.
  assign l2_read  = (state_q != IDLE) & cap_read_q;
  assign l2_write = (state_q != IDLE) & cap_write_q;
  assign l2_addr  = cap_addr_q;
  assign l2_wdata = cap_wdata_q;
  assign i_rdata  = l2_rdata;
  assign d_rdata  = l2_rdata;

  sat_counter #(.W(CNT_W)) u_cnt_i_grant (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_i),
    .count (cnt_i_grant)
  );

  sat_counter #(.W(CNT_W)) u_cnt_d_grant (
    .clk   (clk),
    .reset (reset),
    .inc   (grant_d),
    .count (cnt_d_grant)
  );

  sat_counter #(.W(CNT_W)) u_cnt_conflict (
    .clk   (clk),
    .reset (reset),
    .inc   (conflict),
    .count (cnt_conflict)
  );

endmodule

// File: tb/tb_l2_arbiter.sv
// Bench for l2_arbiter: directed scenarios plus a randomized run against a
// transaction-level model. A second instance with 4-bit counters shares all inputs.
module tb_l2_arbiter;

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 256;
  localparam int unsigned CW = 32;
  localparam int unsigned SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic          i_read, d_read, d_write, l2_resp;
  logic [AW-1:0] i_addr, d_addr;
  logic [LW-1:0] d_wdata, l2_rdata;

  logic [LW-1:0] i_rdata, d_rdata, l2_wdata;
  logic          i_resp, d_resp, l2_read, l2_write;
  logic [AW-1:0] l2_addr;
  logic [CW-1:0] cnt_i_grant, cnt_d_grant, cnt_conflict;

  logic [LW-1:0] s_i_rdata, s_d_rdata, s_l2_wdata;
  logic          s_i_resp, s_d_resp, s_l2_read, s_l2_write;
  logic [AW-1:0] s_l2_addr;
  logic [SW-1:0] s_cnt_i_grant, s_cnt_d_grant, s_cnt_conflict;

  int checks = 0;
  int errors = 0;

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .l2_read(l2_read), .l2_write(l2_write), .l2_addr(l2_addr), .l2_wdata(l2_wdata),
    .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .cnt_i_grant(cnt_i_grant), .cnt_d_grant(cnt_d_grant), .cnt_conflict(cnt_conflict)
  );

  l2_arbiter #(.ADDR_W(AW), .LINE_W(LW), .CNT_W(SW)) dut_sat (
    .clk(clk), .reset(reset),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(s_i_rdata), .i_resp(s_i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(s_d_rdata), .d_resp(s_d_resp),
    .l2_read(s_l2_read), .l2_write(s_l2_write), .l2_addr(s_l2_addr),
    .l2_wdata(s_l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
    .cnt_i_grant(s_cnt_i_grant), .cnt_d_grant(s_cnt_d_grant),
    .cnt_conflict(s_cnt_conflict)
  );

  // Reference model state (transaction level).
  int            m_own;      // 0 none, 1 I-cache, 2 D-cache
  bit            m_last_i;   // last grant went to the I-cache
  bit            m_wr;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  int            m_ci, m_cd, m_cc;

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] r;
    for (int i = 0; i < LW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [SW-1:0] sat4(input int v);
    return (v > 15) ? 4'd15 : SW'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_read = 0; d_read = 0; d_write = 0; l2_resp = 0;
    i_addr = '0; d_addr = '0; d_wdata = '0; l2_rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1;
    idle_inputs();
    tick();
    tick();
    reset = 0;
    m_own = 0; m_last_i = 0; m_wr = 0; m_addr = '0; m_wdata = '0;
    m_ci = 0; m_cd = 0; m_cc = 0;
  endtask

  task automatic test_reset();
    do_reset();
    #3;
    checks++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b expected 0000", {l2_read, l2_write, i_resp, d_resp});
    end
    checks++;
    if (l2_addr !== '0 || l2_wdata !== '0) begin
      errors++;
      $display("FAIL reset_bus: addr %h wdata %h expected zero", l2_addr, l2_wdata);
    end
    checks++;
    if ({cnt_i_grant, cnt_d_grant, cnt_conflict} !== '0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d %0d %0d expected 0 0 0",
               cnt_i_grant, cnt_d_grant, cnt_conflict);
    end
    tick();
  endtask

  task automatic test_lone_i();
    logic [3:0]    exp;
    logic [LW-1:0] rd;
    do_reset();
    for (int c = 0; c <= 6; c++) begin
      rd = rand_line();
      i_read = (c <= 5); i_addr = 32'h0000_1000; l2_resp = (c == 5); l2_rdata = rd;
      #3;
      exp = (c >= 1 && c <= 5) ? 4'b1000 : 4'b0000;
      if (c == 5) exp = 4'b1010;
      checks++;
      if ({l2_read, l2_write, i_resp, d_resp} !== exp) begin
        errors++;
        $display("FAIL lone_i_ctrl c%0d: got %b expected %b", c,
                 {l2_read, l2_write, i_resp, d_resp}, exp);
      end
      if (c >= 1 && c <= 5) begin
        checks++;
        if (l2_addr !== 32'h0000_1000) begin
          errors++;
          $display("FAIL lone_i_addr c%0d: got %h expected 00001000", c, l2_addr);
        end
      end
      if (c == 5) begin
        checks++;
        if (i_rdata !== rd) begin
          errors++;
          $display("FAIL lone_i_rdata: got %h expected %h", i_rdata, rd);
        end
      end
      tick();
    end
    checks++;
    if (cnt_i_grant !== 32'd1 || cnt_d_grant !== 32'd0) begin
      errors++;
      $display("FAIL lone_i_cnt: got i=%0d d=%0d expected 1 0", cnt_i_grant, cnt_d_grant);
    end
  endtask

  task automatic test_lone_d_write();
    logic [3:0]    exp;
    logic [LW-1:0] w, rd;
    w = {32{8'hA5}};
    do_reset();
    for (int c = 0; c <= 4; c++) begin
      rd = rand_line();
      d_write = (c <= 3); d_read = (c <= 3); d_addr = 32'h0000_2040; d_wdata = w;
      l2_resp = (c == 3); l2_rdata = rd;
      #3;
      exp = (c >= 1 && c <= 3) ? 4'b0100 : 4'b0000;
      if (c == 3) exp = 4'b0101;
      checks++;
      if ({l2_read, l2_write, i_resp, d_resp} !== exp) begin
        errors++;
        $display("FAIL lone_d_ctrl c%0d: got %b expected %b", c,
                 {l2_read, l2_write, i_resp, d_resp}, exp);
      end
      if (c >= 1 && c <= 3) begin
        checks++;
        if (l2_addr !== 32'h0000_2040 || l2_wdata !== w) begin
          errors++;
          $display("FAIL lone_d_bus c%0d: addr %h wdata %h", c, l2_addr, l2_wdata);
        end
      end
      if (c == 3) begin
        checks++;
        if (i_rdata !== rd || d_rdata !== rd) begin
          errors++;
          $display("FAIL lone_d_rdata: got i=%h d=%h expected %h", i_rdata, d_rdata, rd);
        end
      end
      tick();
    end
    checks++;
    if (cnt_d_grant !== 32'd1 || cnt_i_grant !== 32'd0) begin
      errors++;
      $display("FAIL lone_d_cnt: got i=%0d d=%0d expected 0 1", cnt_i_grant, cnt_d_grant);
    end
  endtask

  // Both caches request without pause; each transaction is grant, wait, respond.
  task automatic test_back_to_back();
    logic [3:0]    exp;
    logic [AW-1:0] ea;
    bit            own_i;
    do_reset();
    for (int c = 0; c <= 12; c++) begin
      i_read = (c < 12); d_read = (c < 12);
      i_addr = 32'h0000_0100; d_addr = 32'h0000_0200;
      l2_resp = (c < 12) && (c % 3 == 2);
      #3;
      own_i = ((c / 3) % 2) == 0;
      ea = own_i ? 32'h0000_0100 : 32'h0000_0200;
      if (c >= 12 || c % 3 == 0) exp = 4'b0000;
      else if (c % 3 == 1) exp = 4'b1000;
      else exp = own_i ? 4'b1010 : 4'b1001;
      checks++;
      if ({l2_read, l2_write, i_resp, d_resp} !== exp) begin
        errors++;
        $display("FAIL b2b_ctrl c%0d: got %b expected %b", c,
                 {l2_read, l2_write, i_resp, d_resp}, exp);
      end
      if (c < 12 && c % 3 != 0) begin
        checks++;
        if (l2_addr !== ea) begin
          errors++;
          $display("FAIL b2b_addr c%0d: got %h expected %h", c, l2_addr, ea);
        end
      end
      tick();
    end
    checks++;
    if (cnt_conflict !== 32'd4 || cnt_i_grant !== 32'd2 || cnt_d_grant !== 32'd2) begin
      errors++;
      $display("FAIL b2b_cnt: got c=%0d i=%0d d=%0d expected 4 2 2",
               cnt_conflict, cnt_i_grant, cnt_d_grant);
    end
  endtask

  task automatic test_addr_hold();
    logic [3:0] exp;
    do_reset();
    for (int c = 0; c <= 5; c++) begin
      d_read = (c <= 4);
      d_addr = (c == 0) ? 32'h0000_3000 : $urandom;
      d_write = (c >= 1 && c <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      d_wdata = rand_line();
      i_read = (c >= 1 && c <= 4) ? 1'($urandom_range(0, 1)) : 1'b0;
      i_addr = $urandom;
      l2_resp = (c == 4);
      #3;
      exp = (c >= 1 && c <= 4) ? 4'b1000 : 4'b0000;
      if (c == 4) exp = 4'b1001;
      checks++;
      if ({l2_read, l2_write, i_resp, d_resp} !== exp) begin
        errors++;
        $display("FAIL hold_ctrl c%0d: got %b expected %b", c,
                 {l2_read, l2_write, i_resp, d_resp}, exp);
      end
      if (c >= 1 && c <= 4) begin
        checks++;
        if (l2_addr !== 32'h0000_3000) begin
          errors++;
          $display("FAIL hold_addr c%0d: got %h expected 00003000", c, l2_addr);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    i_read = 1; i_addr = 32'h0000_4000;
    tick();
    #3;
    checks++;
    if (l2_read !== 1'b1) begin
      errors++;
      $display("FAIL mid_busy: got l2_read=%b expected 1", l2_read);
    end
    tick();
    reset = 1;
    tick();
    // Stray response after the abort must not reach the I-cache.
    reset = 0; i_read = 0; l2_resp = 1;
    #3;
    checks++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000 || l2_addr !== '0) begin
      errors++;
      $display("FAIL mid_abort: got ctrl=%b addr=%h expected 0000 0",
               {l2_read, l2_write, i_resp, d_resp}, l2_addr);
    end
    checks++;
    if ({cnt_i_grant, cnt_d_grant, cnt_conflict} !== '0) begin
      errors++;
      $display("FAIL mid_cnt: got %0d %0d %0d expected 0 0 0",
               cnt_i_grant, cnt_d_grant, cnt_conflict);
    end
    tick();
    l2_resp = 0;
    #3;
    checks++;
    if ({l2_read, l2_write, i_resp, d_resp} !== 4'b0000) begin
      errors++;
      $display("FAIL mid_after: got %b expected 0000", {l2_read, l2_write, i_resp, d_resp});
    end
    tick();
  endtask

  task automatic test_saturation();
    do_reset();
    for (int t = 0; t <= 20; t++) begin
      #3;
      checks++;
      if (s_cnt_i_grant !== sat4(t) || cnt_i_grant !== 32'(t)) begin
        errors++;
        $display("FAIL sat_cnt t%0d: got narrow=%0d wide=%0d expected %0d %0d",
                 t, s_cnt_i_grant, cnt_i_grant, sat4(t), t);
      end
      if (t == 20) break;
      i_read = 1; i_addr = 32'(t);
      tick();
      l2_resp = 1;
      #3;
      checks++;
      if (s_i_resp !== 1'b1) begin
        errors++;
        $display("FAIL sat_resp t%0d: got %b expected 1", t, s_i_resp);
      end
      tick();
      i_read = 0; l2_resp = 0;
      tick();
    end
  endtask

  task automatic test_random();
    bit            p_iresp, p_dresp, ri, rd;
    logic [3:0]    exp;
    do_reset();
    p_iresp = 0; p_dresp = 0;
    for (int c = 0; c < 800; c++) begin
      i_read  = p_iresp ? 1'b0 : 1'($urandom_range(0, 1));
      d_read  = p_dresp ? 1'b0 : 1'($urandom_range(0, 1));
      d_write = p_dresp ? 1'b0 : 1'($urandom_range(0, 2) == 0);
      i_addr = $urandom; d_addr = $urandom;
      d_wdata = rand_line(); l2_rdata = rand_line();
      l2_resp = (m_own != 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
      #3;
      exp = {m_own != 0 && !m_wr, m_own != 0 && m_wr,
             m_own == 1 && l2_resp, m_own == 2 && l2_resp};
      checks++;
      if ({l2_read, l2_write, i_resp, d_resp} !== exp ||
          {s_l2_read, s_l2_write, s_i_resp, s_d_resp} !== exp) begin
        errors++;
        $display("FAIL rnd_ctrl c%0d: got %b/%b expected %b", c,
                 {l2_read, l2_write, i_resp, d_resp},
                 {s_l2_read, s_l2_write, s_i_resp, s_d_resp}, exp);
      end
      if (m_own != 0) begin
        checks++;
        if (l2_addr !== m_addr || (m_wr && l2_wdata !== m_wdata)) begin
          errors++;
          $display("FAIL rnd_bus c%0d: addr %h expected %h", c, l2_addr, m_addr);
        end
      end
      checks++;
      if (i_rdata !== l2_rdata || d_rdata !== l2_rdata) begin
        errors++;
        $display("FAIL rnd_rdata c%0d: got i=%h d=%h", c, i_rdata, d_rdata);
      end
      checks++;
      if ({cnt_i_grant, cnt_d_grant, cnt_conflict} !== {32'(m_ci), 32'(m_cd), 32'(m_cc)} ||
          {s_cnt_i_grant, s_cnt_d_grant, s_cnt_conflict} !==
          {sat4(m_ci), sat4(m_cd), sat4(m_cc)}) begin
        errors++;
        $display("FAIL rnd_cnt c%0d: got %0d %0d %0d / %0d %0d %0d expected %0d %0d %0d",
                 c, cnt_i_grant, cnt_d_grant, cnt_conflict, s_cnt_i_grant,
                 s_cnt_d_grant, s_cnt_conflict, m_ci, m_cd, m_cc);
      end
      p_iresp = exp[1];
      p_dresp = exp[0];
      if (m_own == 0) begin
        ri = i_read;
        rd = d_read | d_write;
        if (ri && rd) m_cc++;
        if (ri && (!rd || !m_last_i)) begin
          m_own = 1; m_last_i = 1; m_wr = 0; m_addr = i_addr; m_ci++;
        end else if (rd) begin
          m_own = 2; m_last_i = 0; m_wr = d_write; m_addr = d_addr; m_wdata = d_wdata;
          m_cd++;
        end
      end else if (l2_resp) begin
        m_own = 0;
      end
      tick();
    end
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    test_reset();
    test_lone_i();
    test_lone_d_write();
    test_back_to_back();
    test_addr_hold();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
